mem_port_arbiter: RTL and testbench

//   Shares one single-ported SRAM between the instruction-fetch requester (IF)
//   and the load/store requester (DM), for the multi-cycle/pipelined core variant.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch (IF) and load/store (DM).
// Grants are issued in the request cycle; read data returns one cycle later to its owner.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [3:0]        dm_w_en,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_w_en,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       conflict_cnt
);

   localparam int unsigned SW = 4;
   localparam int unsigned CW = 16;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   logic [SW-1:0]     starve_q, starve_d;
   logic              rd_pend_q, rd_pend_d;
   owner_e            rd_owner_q, rd_owner_d;
   logic [CW-1:0]     conflict_q, conflict_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              conflict;

   // Arbitration and SRAM drive; nothing is granted while reset is asserted.
   always_comb begin
      if_gnt      = 1'b0;
      dm_gnt      = 1'b0;
      mem_address = '0;
      mem_w_en    = 4'b0000;
      mem_wdata   = '0;
      conflict    = if_req & dm_req;
      if (rst) begin
         if (conflict) begin
            if (starve_q == SW'(STARVE_MAX)) if_gnt = 1'b1;
            else                             dm_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end else if (dm_req) begin
            dm_gnt = 1'b1;
         end
      end
      if (if_gnt) begin
         mem_address = if_addr;
      end else if (dm_gnt) begin
         mem_address = dm_addr;
         mem_w_en    = dm_w_en;
         mem_wdata   = dm_wdata;
      end
   end

   // Next-state for starvation, read tracking, conflict counter and read-data holding.
   always_comb begin
      starve_d   = starve_q;
      rd_pend_d  = if_gnt | (dm_gnt & (dm_w_en == 4'b0000));
      rd_owner_d = rd_owner_q;
      conflict_d = conflict_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;

      if (if_gnt)                  starve_d = '0;
      else if (conflict && dm_gnt) starve_d = starve_q + SW'(1);

      if (dm_gnt)      rd_owner_d = OWN_DM;
      else if (if_gnt) rd_owner_d = OWN_IF;

      if (conflict && (conflict_q != {CW{1'b1}})) conflict_d = conflict_q + CW'(1);

      if (if_rvalid) if_rdata_d = mem_rdata;
      if (dm_rvalid) dm_rdata_d = mem_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q   <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= OWN_IF;
         conflict_q <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         starve_q   <= starve_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         conflict_q <= conflict_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // SRAM data arrives in the return cycle, so the owner sees it directly.
   assign if_rvalid    = rd_pend_q & (rd_owner_q == OWN_IF);
   assign dm_rvalid    = rd_pend_q & (rd_owner_q == OWN_DM);
   assign if_rdata     = if_rdata_d;
   assign dm_rdata     = dm_rdata_d;
   assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read SRAM model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req;
   logic [15:0] if_addr, dm_addr;
   logic [3:0]  dm_w_en;
   logic [31:0] dm_wdata;
   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
   logic [31:0] if_rdata, dm_rdata;
   logic [15:0] mem_address;
   logic [3:0]  mem_w_en;
   logic [31:0] mem_wdata, mem_rdata;
   logic [15:0] conflict_cnt;

   logic [31:0] sram [0:16383];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_addr(dm_addr), .dm_w_en(dm_w_en), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_address(mem_address), .mem_w_en(mem_w_en), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
   );

   // Synchronous SRAM: read data valid the cycle after the address, byte-enabled writes.
   always @(posedge clk) begin
      mem_rdata <= sram[mem_address[15:2]];
      for (int b = 0; b < 4; b++)
         if (mem_w_en[b]) sram[mem_address[15:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
   end

   task automatic idle_inputs();
      if_req = 0; dm_req = 0; if_addr = '0; dm_addr = '0; dm_w_en = '0; dm_wdata = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      idle_inputs();
      if_req = 1; dm_req = 1; if_addr = 16'h0010; dm_addr = 16'h0200; dm_w_en = 4'hF;
      dm_wdata = 32'h12345678;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid});
      end
      n_checks++;
      if ({mem_address, mem_w_en, mem_wdata, conflict_cnt, if_rdata, dm_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h wen %h wdata %h cnt %h ifr %h dmr %h expected all 0",
                  mem_address, mem_w_en, mem_wdata, conflict_cnt, if_rdata, dm_rdata);
      end
      idle_inputs();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_if_only();
      @(negedge clk);
      if_req = 1; if_addr = 16'h0010;
      #1;
      n_checks++;
      if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || mem_address !== 16'h0010 || mem_w_en !== 4'b0000) begin
         n_fail++;
         $display("FAIL if_only_gnt: if_gnt %b dm_gnt %b addr %h wen %b expected 1 0 0010 0000",
                  if_gnt, dm_gnt, mem_address, mem_w_en);
      end
      @(posedge clk); #1;
      if_req = 0;
      n_checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || dm_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL if_only_ret: rvalid %b rdata %h dm_rvalid %b expected 1 00500093 0",
                  if_rvalid, if_rdata, dm_rvalid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (if_rvalid !== 1'b0 || if_rdata !== 32'h00500093) begin
         n_fail++;
         $display("FAIL if_only_hold: rvalid %b rdata %h expected 0 00500093", if_rvalid, if_rdata);
      end
   endtask

   task automatic test_dm_store();
      @(negedge clk);
      dm_req = 1; dm_addr = 16'h0200; dm_w_en = 4'b0011; dm_wdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_w_en !== 4'b0011 ||
          mem_address !== 16'h0200 || mem_wdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL dm_store_drive: gnt %b wen %b addr %h wdata %h expected 1 0011 0200 deadbeef",
                  dm_gnt, mem_w_en, mem_address, mem_wdata);
      end
      @(posedge clk); #1;
      dm_req = 0; dm_w_en = 0; dm_wdata = 0;
      n_checks++;
      if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL dm_store_norv: dm_rvalid %b if_rvalid %b expected 0 0", dm_rvalid, if_rvalid);
      end
      @(negedge clk);
      dm_req = 1; dm_addr = 16'h0200;
      #1;
      n_checks++;
      if (mem_wdata !== 32'h0 || mem_w_en !== 4'b0000 || dm_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL dm_read_drive: wdata %h wen %b gnt %b expected 0 0000 1", mem_wdata, mem_w_en, dm_gnt);
      end
      @(posedge clk); #1;
      dm_req = 0;
      n_checks++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hCAFEBEEF || if_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL dm_readback: rvalid %b rdata %h if_rvalid %b expected 1 cafebeef 0",
                  dm_rvalid, dm_rdata, if_rvalid);
      end
   endtask

   task automatic test_fairness();
      logic [9:0] exp_if = 10'b10_0001_0000;
      apply_reset();
      if_req = 1; if_addr = 16'h0000; dm_req = 1; dm_addr = 16'h0100; dm_w_en = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if (if_gnt !== exp_if[i] || dm_gnt !== !exp_if[i]) begin
            n_fail++;
            $display("FAIL fair_cycle%0d: if_gnt %b dm_gnt %b expected %b %b",
                     i, if_gnt, dm_gnt, exp_if[i], !exp_if[i]);
         end
         @(negedge clk);
      end
      idle_inputs();
      #1;
      n_checks++;
      if (conflict_cnt !== 16'd10) begin
         n_fail++;
         $display("FAIL fair_conflicts: got %0d expected 10", conflict_cnt);
      end
   endtask

   task automatic test_pipelined();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if_req = (i % 2 == 0); dm_req = (i % 2 == 1);
         if_addr = 16'h0000; dm_addr = 16'h0100; dm_w_en = 0;
         #1;
         n_checks++;
         if (if_gnt !== (i % 2 == 0) || dm_gnt !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL pipe_gnt%0d: if_gnt %b dm_gnt %b", i, if_gnt, dm_gnt);
         end
         @(posedge clk); #1;
         n_checks++;
         if (i % 2 == 0) begin
            if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0 || if_rdata !== 32'h11110000) begin
               n_fail++;
               $display("FAIL pipe_ret%0d: if_rv %b dm_rv %b if_rdata %h expected 1 0 11110000",
                        i, if_rvalid, dm_rvalid, if_rdata);
            end
         end else begin
            if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0 || dm_rdata !== 32'h22220100) begin
               n_fail++;
               $display("FAIL pipe_ret%0d: dm_rv %b if_rv %b dm_rdata %h expected 1 0 22220100",
                        i, dm_rvalid, if_rvalid, dm_rdata);
            end
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      dm_req = 1; dm_addr = 16'h0100; dm_w_en = 0;
      #1;
      n_checks++;
      if (dm_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_gnt: got %b expected 1", dm_gnt);
      end
      #2;
      rst = 0;
      #1;
      n_checks++;
      if ({dm_gnt, dm_rvalid, if_rvalid, mem_w_en} !== 7'b0 || mem_address !== 16'h0 ||
          conflict_cnt !== 16'h0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_vals: gnt %b dm_rv %b if_rv %b addr %h cnt %h dmr %h ifr %h expected zeros",
                  dm_gnt, dm_rvalid, if_rvalid, mem_address, conflict_cnt, dm_rdata, if_rdata);
      end
      dm_req = 0;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1;
      n_checks++;
      if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_stale: dm_rv %b if_rv %b dm_rdata %h expected 0 0 0",
                  dm_rvalid, if_rvalid, dm_rdata);
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      if_req = 1; dm_req = 1; if_addr = 16'h0000; dm_addr = 16'h0100; dm_w_en = 0;
      repeat (65534) @(posedge clk);
      #1;
      n_checks++;
      if (conflict_cnt !== 16'hFFFE) begin
         n_fail++;
         $display("FAIL sat_before: got %h expected fffe", conflict_cnt);
      end
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (conflict_cnt !== 16'hFFFF || (if_gnt & dm_gnt) !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_hold: cnt %h both_gnt %b expected ffff 0", conflict_cnt, if_gnt & dm_gnt);
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
      sram[16'h0000 >> 2] = 32'h11110000;
      sram[16'h0010 >> 2] = 32'h00500093;
      sram[16'h0100 >> 2] = 32'h22220100;
      sram[16'h0200 >> 2] = 32'hCAFE0000;
      test_reset();
      test_if_only();
      test_dm_store();
      test_fairness();
      test_pipelined();
      test_reset_mid_read();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
